// File: rtl/ab_stream_feeder.sv
// ab_stream_feeder: reads A and B operand words from a shared SRAM and presents
//   them as two independent valid/pass streams. Each stream has a 4-entry FIFO.
// Latency: start at cycle 0, first A read at cycle 1, valid_a_out at cycle 4 (2-cycle SRAM).
// Backpressure: a stream stops issuing reads once its FIFO occupancy plus in-flight
//   reads reach 4. The other stream keeps using the read port.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, base_a, base_b, rounds   job request (sampled while busy=0)
//   mem_re, mem_addr, mem_rdata     SRAM read port (data 2 cycles after mem_re)
//   data_x_out, valid_x_out, pass_en_x_in   stream heads and consumer pops (x = a, b)
//   busy, done, proto_err      job status, one-cycle completion pulse, sticky pop-on-empty flag
module ab_stream_feeder #(
  parameter int D_WIDTH     = 64,
  parameter int A_NUM_WIDTH = 1,
  parameter int B_NUM_WIDTH = 1,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [7:0]            rounds,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [D_WIDTH-1:0]    mem_rdata,
  output logic [D_WIDTH-1:0]    data_a_out,
  output logic [D_WIDTH-1:0]    data_b_out,
  output logic                  valid_a_out,
  output logic                  valid_b_out,
  input  logic                  pass_en_a_in,
  input  logic                  pass_en_b_in,
  output logic                  busy,
  output logic                  done,
  output logic                  proto_err
);
  localparam int NW = (A_NUM_WIDTH > B_NUM_WIDTH) ? A_NUM_WIDTH : B_NUM_WIDTH;
  localparam int RW = 8 + NW;

  // Index 0 = stream A, index 1 = stream B.
  logic [ADDR_WIDTH-1:0] ptr    [2];
  logic [RW-1:0]         rem    [2];
  logic [1:0]            infl   [2];
  logic [2:0]            cnt    [2];
  logic [1:0]            rd_ptr [2];
  logic [1:0]            wr_ptr [2];
  logic [D_WIDTH-1:0]    fifo   [2][4];

  logic last_b;               // last grant went to B; reset value makes A win the first tie
  logic t1_vld, t1_ch;        // tag pipeline, stage 2 lines up with mem_rdata
  logic t2_vld, t2_ch;

  logic [1:0]    pass, vld, elig, grant, pop, push;
  logic [RW-1:0] rem_nxt  [2];
  logic [1:0]    infl_nxt [2];
  logic [2:0]    cnt_nxt  [2];
  logic          idle_nxt;

  always_comb begin
    pass     = {pass_en_b_in, pass_en_a_in};
    vld      = 2'b00;
    elig     = 2'b00;
    pop      = 2'b00;
    push     = 2'b00;
    grant    = 2'b00;
    idle_nxt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      vld[c]  = (cnt[c] != 3'd0);
      // Reserve a FIFO slot for every read already in flight.
      elig[c] = busy && (rem[c] != '0) && ((4'(cnt[c]) + 4'(infl[c])) < 4'd4);
      pop[c]  = pass[c] && vld[c];
      push[c] = t2_vld && (t2_ch == 1'(c));
    end
    if (elig == 2'b11) grant = last_b ? 2'b01 : 2'b10;
    else               grant = elig;
    for (int c = 0; c < 2; c++) begin
      rem_nxt[c]  = rem[c] - RW'(grant[c]);
      infl_nxt[c] = infl[c] + 2'(grant[c]) - 2'(push[c]);
      cnt_nxt[c]  = cnt[c] + 3'(push[c]) - 3'(pop[c]);
      if ((rem_nxt[c] != '0) || (infl_nxt[c] != 2'd0) || (cnt_nxt[c] != 3'd0)) idle_nxt = 1'b0;
    end
  end

  assign mem_re      = |grant;
  assign mem_addr    = grant[1] ? ptr[1] : (grant[0] ? ptr[0] : '0);
  assign valid_a_out = vld[0];
  assign valid_b_out = vld[1];
  assign data_a_out  = vld[0] ? fifo[0][rd_ptr[0]] : '0;
  assign data_b_out  = vld[1] ? fifo[1][rd_ptr[1]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      proto_err <= 1'b0;
      last_b    <= 1'b1;
      t1_vld    <= 1'b0;
      t1_ch     <= 1'b0;
      t2_vld    <= 1'b0;
      t2_ch     <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        ptr[c]    <= '0;
        rem[c]    <= '0;
        infl[c]   <= 2'd0;
        cnt[c]    <= 3'd0;
        rd_ptr[c] <= 2'd0;
        wr_ptr[c] <= 2'd0;
      end
    end else begin
      done   <= 1'b0;
      t1_vld <= mem_re;
      t1_ch  <= grant[1];
      t2_vld <= t1_vld;
      t2_ch  <= t1_ch;
      if (mem_re) last_b <= grant[1];
      // A pop on an empty stream changes nothing except this sticky flag.
      if ((pass & ~vld) != 2'b00) proto_err <= 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (grant[c]) ptr[c] <= ptr[c] + 1'b1;
        rem[c]  <= rem_nxt[c];
        infl[c] <= infl_nxt[c];
        cnt[c]  <= cnt_nxt[c];
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 2'd1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 2'd1;
      end
      if (!busy) begin
        if (start) begin
          ptr[0] <= base_a;
          ptr[1] <= base_b;
          rem[0] <= RW'(rounds) << A_NUM_WIDTH;
          rem[1] <= RW'(rounds) << B_NUM_WIDTH;
          // An empty job completes straight away without ever going busy.
          if (rounds == 8'd0) done <= 1'b1;
          else                busy <= 1'b1;
        end
      end else if (idle_nxt) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: heads are gated by the (reset) occupancy counts.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) fifo[c][wr_ptr[c]] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ab_stream_feeder.sv
// Bench for ab_stream_feeder: SRAM model with 2-cycle read latency, consumer
//   driving pass enables, reference streams computed directly from base + k.
// Checks per scenario task; summary line at the end.
module tb_ab_stream_feeder;
  localparam int DW = 64;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_a, base_b;
  logic [7:0]    rounds;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] data_a_out, data_b_out;
  logic          valid_a_out, valid_b_out;
  logic          pass_en_a, pass_en_b;
  logic          busy, done, proto_err;

  ab_stream_feeder #(.D_WIDTH(DW), .A_NUM_WIDTH(1), .B_NUM_WIDTH(1), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b),
    .rounds(rounds), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .data_a_out(data_a_out), .data_b_out(data_b_out),
    .valid_a_out(valid_a_out), .valid_b_out(valid_b_out),
    .pass_en_a_in(pass_en_a), .pass_en_b_in(pass_en_b),
    .busy(busy), .done(done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // SRAM contents and read-port model.
  logic [DW-1:0] mem [1024];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            re_cyc [$];
  logic [AW-1:0] re_addr [$];
  logic          h1_re = 1'b0, h2_re = 1'b0;
  logic [AW-1:0] h1_a = '0, h2_a = '0;

  always @(negedge clk) begin
    if (h2_re) mem_rdata = mem[h2_a];
    else       mem_rdata = {$urandom, $urandom};
    h2_re = h1_re; h2_a = h1_a;
    h1_re = mem_re; h1_a = mem_addr;
    if (mem_re) begin
      re_cyc.push_back(cyc);
      re_addr.push_back(mem_addr);
    end
  end

  // Results of the last job run.
  logic [DW-1:0] got_a [$];
  logic [DW-1:0] got_b [$];
  int pop_b_cyc [$];
  int done_cyc [$];
  int last_pop, first_va, first_vb, start_cyc, re_base;
  bit timed_out, any_valid, any_busy, busy_at_done;

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pass_en_a = 1'b0; pass_en_b = 1'b0;
    base_a = '0; base_b = '0; rounds = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: pop whenever valid (A after stall_a); 1: pass enables held high; 2: random pops.
  task automatic run_job(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [7:0] r,
                         input int stall_a, input int mode, input int restart_at, input int abort_at);
    bit want_a, want_b;
    got_a.delete(); got_b.delete(); pop_b_cyc.delete(); done_cyc.delete();
    last_pop = -1; first_va = -1; first_vb = -1;
    any_valid = 0; any_busy = 0; busy_at_done = 0; timed_out = 1;
    re_base = re_cyc.size();
    @(negedge clk);
    base_a = ba; base_b = bb; rounds = r; start = 1'b1; start_cyc = cyc;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (k == restart_at) begin
        base_a = ~ba; base_b = ~bb; rounds = 8'hff;
      end
      if (valid_a_out || valid_b_out) any_valid = 1;
      if (busy) any_busy = 1;
      if (valid_a_out && first_va < 0) first_va = k;
      if (valid_b_out && first_vb < 0) first_vb = k;
      if (done) begin
        done_cyc.push_back(k);
        if (busy) busy_at_done = 1;
      end
      want_a = (k > stall_a) && ((mode != 2) || ($urandom_range(0, 3) != 0));
      want_b = (mode != 2) || ($urandom_range(0, 2) != 0);
      if (mode == 1) begin
        pass_en_a = 1'b1; pass_en_b = 1'b1;
      end else begin
        pass_en_a = want_a && valid_a_out;
        pass_en_b = want_b && valid_b_out;
      end
      if (pass_en_a && valid_a_out) begin got_a.push_back(data_a_out); last_pop = k; end
      if (pass_en_b && valid_b_out) begin
        got_b.push_back(data_b_out); pop_b_cyc.push_back(k); last_pop = k;
      end
      if (k == abort_at) begin timed_out = 0; break; end
      if (done_cyc.size() > 0 && k >= done_cyc[0] + 3) begin timed_out = 0; break; end
    end
    start = 1'b0; pass_en_a = 1'b0; pass_en_b = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({valid_a_out, valid_b_out, mem_re, busy, done, proto_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000",
               {valid_a_out, valid_b_out, mem_re, busy, done, proto_err});
    end
    n_tests++;
    if ({data_a_out, data_b_out, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: data_a %h data_b %h addr %h required all zero",
               data_a_out, data_b_out, mem_addr);
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea [4];
    int bad;
    ea[0] = 10'h010; ea[1] = 10'h100; ea[2] = 10'h011; ea[3] = 10'h101;
    do_reset();
    run_job(10'h010, 10'h100, 8'd1, 0, 1, -1, -1);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
    bad = 0;
    if (re_cyc.size() - re_base != 4) bad = 1;
    else for (int i = 0; i < 4; i++)
      if (re_cyc[re_base + i] - start_cyc != i + 1 || re_addr[re_base + i] !== ea[i]) bad = 1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL basic_reads: %0d reads seen, required 4 at cycles 1..4 addrs 010,100,011,101",
               re_cyc.size() - re_base);
    end
    n_tests++;
    if (first_va != 4 || first_vb != 5) begin
      n_fail++;
      $display("FAIL basic_valid_cycle: valid_a at %0d valid_b at %0d, required 4 and 5", first_va, first_vb);
    end
    n_tests++;
    if (got_a.size() != 2 || got_a[0] !== mem[10'h010] || got_a[1] !== mem[10'h011] ||
        got_b.size() != 2 || got_b[0] !== mem[10'h100] || got_b[1] !== mem[10'h101]) begin
      n_fail++;
      $display("FAIL basic_data: got %0d A and %0d B words or wrong values, required 2+2 from 010/100",
               got_a.size(), got_b.size());
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != 8 || last_pop != 7 || busy_at_done) begin
      n_fail++;
      $display("FAIL basic_done: %0d pulses first at %0d last pop %0d busy %0d, required 1 pulse at 8 after pop 7, busy 0",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, last_pop, busy_at_done);
    end
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_proto_err: got %b required 1 (pass held while empty)", proto_err);
    end
  endtask

  task automatic test_backpressure();
    int a_early, bad;
    do_reset();
    run_job(10'h200, 10'h300, 8'd4, 20, 0, -1, -1);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
    a_early = 0;
    for (int i = re_base; i < re_cyc.size(); i++)
      if (re_cyc[i] - start_cyc <= 20 && re_addr[i] >= 10'h200 && re_addr[i] < 10'h208) a_early++;
    n_tests++;
    if (a_early != 4) begin
      n_fail++;
      $display("FAIL bp_a_reads: %0d A reads during stall, required 4", a_early);
    end
    bad = 0;
    if (got_b.size() != 8) bad = 1;
    else for (int k = 0; k < 8; k++) if (got_b[k] !== mem[10'h300 + k] || pop_b_cyc[k] > 20) bad = 1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_b_stream: %0d B words, required 8 ordered words before A release", got_b.size());
    end
    n_tests++;
    if (got_b.size() == 8 && pop_b_cyc[7] - pop_b_cyc[4] != 3) begin
      n_fail++;
      $display("FAIL bp_b_rate: last 4 B pops span %0d cycles, required 3", pop_b_cyc[7] - pop_b_cyc[4]);
    end
    bad = 0;
    if (got_a.size() != 8) bad = 1;
    else for (int k = 0; k < 8; k++) if (got_a[k] !== mem[10'h200 + k]) bad = 1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_a_stream: %0d A words, required 8 ordered words", got_a.size());
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != last_pop + 1) begin
      n_fail++;
      $display("FAIL bp_done: %0d pulses, last pop %0d, required 1 pulse at last pop + 1", done_cyc.size(), last_pop);
    end
  endtask

  task automatic test_rounds_zero();
    do_reset();
    run_job(10'h055, 10'h0AA, 8'd0, 0, 0, -1, -1);
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != 1) begin
      n_fail++;
      $display("FAIL zero_done: %0d pulses first at %0d, required 1 pulse at cycle 1",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    n_tests++;
    if (re_cyc.size() != re_base || any_valid || any_busy) begin
      n_fail++;
      $display("FAIL zero_quiet: reads %0d valid %0d busy %0d, required none",
               re_cyc.size() - re_base, any_valid, any_busy);
    end
  endtask

  task automatic test_start_while_busy();
    int bad;
    do_reset();
    run_job(10'h020, 10'h140, 8'd2, 0, 0, 2, -1);
    bad = 0;
    if (got_a.size() != 4 || got_b.size() != 4) bad = 1;
    else for (int k = 0; k < 4; k++)
      if (got_a[k] !== mem[10'h020 + k] || got_b[k] !== mem[10'h140 + k]) bad = 1;
    n_tests++;
    if (bad || timed_out || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL restart_ignored: A %0d B %0d words, %0d done pulses, required 4, 4, 1 from original bases",
               got_a.size(), got_b.size(), done_cyc.size());
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    @(negedge clk); pass_en_b = 1'b1;
    @(negedge clk); pass_en_b = 1'b0;
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_set: got %b required 1", proto_err);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (proto_err !== 1'b1 || valid_b_out !== 1'b0 || mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_sticky: proto %b valid_b %b mem_re %b required 1 0 0", proto_err, valid_b_out, mem_re);
    end
    run_job(10'h0A0, 10'h0C0, 8'd1, 0, 0, -1, -1);
    n_tests++;
    if (got_b.size() != 2 || got_b[0] !== mem[10'h0C0] || got_b[1] !== mem[10'h0C1] || proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_after: %0d B words proto %b, required 2 words from 0C0 and proto 1", got_b.size(), proto_err);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a_addrs [$];
    do_reset();
    run_job(10'h3FF, 10'h100, 8'd1, 0, 0, -1, -1);
    for (int i = re_base; i < re_cyc.size(); i++)
      if (!(re_addr[i] >= 10'h100 && re_addr[i] < 10'h102)) a_addrs.push_back(re_addr[i]);
    n_tests++;
    if (a_addrs.size() != 2 || a_addrs[0] !== 10'h3FF || a_addrs[1] !== 10'h000) begin
      n_fail++;
      $display("FAIL wrap_addrs: %0d A reads, required 3FF then 000", a_addrs.size());
    end
    n_tests++;
    if (got_a.size() != 2 || got_a[0] !== mem[10'h3FF] || got_a[1] !== mem[10'h000]) begin
      n_fail++;
      $display("FAIL wrap_data: %0d A words, required mem[3FF], mem[000]", got_a.size());
    end
  endtask

  task automatic test_reset_midjob();
    bit stale;
    int bad;
    do_reset();
    run_job(10'h040, 10'h080, 8'd4, 1000, 0, -1, 6);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({valid_a_out, valid_b_out, mem_re, busy, done} !== 5'b0 || {data_a_out, data_b_out, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags %b data_a %h data_b %h addr %h required all zero",
               {valid_a_out, valid_b_out, mem_re, busy, done}, data_a_out, data_b_out, mem_addr);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_a_out || valid_b_out || mem_re || busy) stale = 1;
    end
    n_tests++;
    if (stale) begin n_fail++; $display("FAIL midreset_stale: activity after reset release, required none"); end
    run_job(10'h060, 10'h070, 8'd2, 0, 0, -1, -1);
    bad = 0;
    if (got_a.size() != 4 || got_b.size() != 4) bad = 1;
    else for (int k = 0; k < 4; k++)
      if (got_a[k] !== mem[10'h060 + k] || got_b[k] !== mem[10'h070 + k]) bad = 1;
    n_tests++;
    if (bad || timed_out || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL midreset_fresh: A %0d B %0d words %0d done, required 4, 4, 1",
               got_a.size(), got_b.size(), done_cyc.size());
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ba, bb;
    logic [7:0] r;
    int bad;
    for (int it = 0; it < 6; it++) begin
      ba = AW'($urandom); bb = AW'($urandom); r = 8'($urandom_range(1, 6));
      do_reset();
      run_job(ba, bb, r, $urandom_range(0, 10), 2, -1, -1);
      bad = 0;
      if (got_a.size() != 2 * r || got_b.size() != 2 * r) bad = 1;
      else for (int k = 0; k < 2 * r; k++)
        if (got_a[k] !== mem[AW'(ba + k)] || got_b[k] !== mem[AW'(bb + k)]) bad = 1;
      n_tests++;
      if (bad || timed_out) begin
        n_fail++;
        $display("FAIL random_streams[%0d]: A %0d B %0d words timeout %0d, required %0d each in address order",
                 it, got_a.size(), got_b.size(), timed_out, 2 * r);
      end
      n_tests++;
      if (done_cyc.size() != 1 || done_cyc[0] != last_pop + 1 || busy_at_done) begin
        n_fail++;
        $display("FAIL random_done[%0d]: %0d pulses last pop %0d busy %0d, required 1 pulse at last pop + 1",
                 it, done_cyc.size(), last_pop, busy_at_done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_basic();
    test_backpressure();
    test_rounds_zero();
    test_start_while_busy();
    test_proto_err();
    test_wrap();
    test_reset_midjob();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
